// File: rtl/instr_seq_checker_if.sv
// Core-facing bus of the instruction sequence checker: reset, instruction feed,
// PC observation and debug register readback.
interface instr_seq_checker_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            cpu_rst;
  logic [XLEN-1:0] imem_out;
  logic [XLEN-1:0] imem_addr;
  logic [4:0]      ra3;
  logic [XLEN-1:0] rd3;

  modport master (
    output cpu_rst, imem_out, ra3,
    input  imem_addr, rd3
  );

  modport slave (
    input  cpu_rst, imem_out, ra3,
    output imem_addr, rd3
  );
endinterface

// File: rtl/instr_seq_checker.sv
// Issues a loadable table of {instr, rd, expect} vectors to a single-cycle core,
// reads rd back through the debug port and keeps pass/fail statistics.
module instr_seq_checker #(
  parameter int unsigned    XLEN          = 32,
  parameter int unsigned    DEPTH         = 16,
  parameter int unsigned    SETTLE_CYCLES = 0,
  parameter logic [XLEN-1:0] NOP_INSTR    = XLEN'(32'h0000_0013)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vec_we,
  input  logic [$clog2(DEPTH)-1:0]   vec_idx,
  input  logic [XLEN-1:0]            vec_instr,
  input  logic [4:0]                 vec_rd,
  input  logic [XLEN-1:0]            vec_expect,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     count,
  instr_seq_checker_if.master        core,
  output logic                       busy,
  output logic                       done,
  output logic                       all_pass,
  output logic [$clog2(DEPTH):0]     pass_cnt,
  output logic [$clog2(DEPTH):0]     fail_cnt,
  output logic [$clog2(DEPTH)-1:0]   first_fail_idx,
  output logic [XLEN-1:0]            first_fail_data,
  output logic [XLEN-1:0]            first_fail_pc
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam logic [3:0]  SettleLast = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StSettle, StCheck, StDone} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      settle_q, settle_d;
  logic [4:0]      ra3_q, ra3_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   pass_q, pass_d, fail_q, fail_d;
  logic [IW-1:0]   ff_idx_q, ff_idx_d;
  logic [XLEN-1:0] ff_data_q, ff_data_d, ff_pc_q, ff_pc_d;

  logic [XLEN-1:0] tab_instr  [DEPTH];
  logic [4:0]      tab_rd     [DEPTH];
  logic [XLEN-1:0] tab_expect [DEPTH];

  logic idle_or_done;
  logic start_ok;

  assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
  assign start_ok     = start && (count != '0) && (count <= CW'(DEPTH));

  // Table is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (vec_we && idle_or_done) begin
      tab_instr[vec_idx]  <= vec_instr;
      tab_rd[vec_idx]     <= vec_rd;
      tab_expect[vec_idx] <= vec_expect;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      count_q   <= '0;
      settle_q  <= '0;
      ra3_q     <= '0;
      pc_q      <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      ff_idx_q  <= '0;
      ff_data_q <= '0;
      ff_pc_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      settle_q  <= settle_d;
      ra3_q     <= ra3_d;
      pc_q      <= pc_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      ff_idx_q  <= ff_idx_d;
      ff_data_q <= ff_data_d;
      ff_pc_q   <= ff_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    settle_d  = settle_q;
    ra3_d     = ra3_q;
    pc_d      = pc_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ff_idx_d  = ff_idx_q;
    ff_data_d = ff_data_q;
    ff_pc_d   = ff_pc_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          count_d   = count;
          idx_d     = '0;
          pass_d    = '0;
          fail_d    = '0;
          ff_idx_d  = '0;
          ff_data_d = '0;
          ff_pc_d   = '0;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        ra3_d = tab_rd[idx_q];
        pc_d  = core.imem_addr;
        if (SETTLE_CYCLES == 0) begin
          state_d = StCheck;
        end else begin
          settle_d = SettleLast;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (settle_q == '0) state_d = StCheck;
        else                settle_d = settle_q - 4'd1;
      end
      StCheck: begin
        if (core.rd3 == tab_expect[idx_q]) begin
          pass_d = pass_q + CW'(1);
        end else begin
          fail_d = fail_q + CW'(1);
          if (fail_q == '0) begin
            ff_idx_d  = idx_q;
            ff_data_d = core.rd3;
            ff_pc_d   = pc_q;
          end
        end
        if ({1'b0, idx_q} == count_q - CW'(1)) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Core only sees reset while idle; DONE keeps its register state for inspection.
  assign core.cpu_rst  = (state_q == StIdle);
  assign core.imem_out = (state_q == StIssue) ? tab_instr[idx_q] : NOP_INSTR;
  assign core.ra3      = (state_q == StIssue) ? tab_rd[idx_q] : ra3_q;

  assign busy            = (state_q == StIssue) || (state_q == StSettle) || (state_q == StCheck);
  assign done            = (state_q == StDone);
  assign all_pass        = done && (fail_q == '0) && (pass_q == count_q);
  assign pass_cnt        = pass_q;
  assign fail_cnt        = fail_q;
  assign first_fail_idx  = ff_idx_q;
  assign first_fail_data = ff_data_q;
  assign first_fail_pc   = ff_pc_q;
endmodule

// File: tb/tb_instr_seq_checker.sv
// Bench for instr_seq_checker: two instances (settle 0 and 3), each driving a tiny
// LUI-only core model; a scoreboard checks every completed run.
module tb_instr_seq_checker;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned IW    = 4;
  localparam int unsigned CW    = 5;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          vec_we = 1'b0;
  logic [IW-1:0] vec_idx = '0;
  logic [31:0]   vec_instr = '0, vec_expect = '0;
  logic [4:0]    vec_rd = '0;
  logic [CW-1:0] count = '0;
  logic          start_w [2];

  logic          busy_w [2], done_w [2], all_pass_w [2], cpu_rst_w [2];
  logic [CW-1:0] pass_w [2], fail_w [2];
  logic [IW-1:0] ffidx_w [2];
  logic [31:0]   ffdata_w [2], ffpc_w [2], imem_w [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    instr_seq_checker_if #(.XLEN(32)) bus ();

    instr_seq_checker #(
      .XLEN(32), .DEPTH(DEPTH), .SETTLE_CYCLES(g * 3), .NOP_INSTR(NOP)
    ) dut (
      .clk(clk), .rst(rst), .vec_we(vec_we), .vec_idx(vec_idx), .vec_instr(vec_instr),
      .vec_rd(vec_rd), .vec_expect(vec_expect), .start(start_w[g]), .count(count),
      .core(bus), .busy(busy_w[g]), .done(done_w[g]), .all_pass(all_pass_w[g]),
      .pass_cnt(pass_w[g]), .fail_cnt(fail_w[g]), .first_fail_idx(ffidx_w[g]),
      .first_fail_data(ffdata_w[g]), .first_fail_pc(ffpc_w[g])
    );

    // Minimal single-cycle core: executes LUI only, PC advances by 4 out of reset.
    logic [31:0] regs [32];
    logic [31:0] pc;
    always_ff @(posedge clk) begin
      if (bus.cpu_rst) begin
        pc <= '0;
        for (int r = 0; r < 32; r++) regs[r] <= '0;
      end else begin
        pc <= pc + 32'd4;
        if (bus.imem_out[6:0] == 7'b0110111 && bus.imem_out[11:7] != 5'd0)
          regs[bus.imem_out[11:7]] <= {bus.imem_out[31:12], 12'h000};
      end
    end
    assign bus.imem_addr = pc;
    assign bus.rd3       = regs[bus.ra3];
    assign cpu_rst_w[g]  = bus.cpu_rst;
    assign imem_w[g]     = bus.imem_out;
  end

  typedef struct {
    int          lat;
    int          pass;
    int          fail;
    bit          allp;
    int          fidx;
    logic [31:0] fdata;
    logic [31:0] fpc;
    int          scyc;
  } exp_t;

  exp_t q0[$], q1[$];
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_vec(input int i, input logic [31:0] ins, input logic [4:0] rd,
                           input logic [31:0] ex);
    @(negedge clk);
    vec_we = 1'b1; vec_idx = IW'(i); vec_instr = ins; vec_rd = rd; vec_expect = ex;
    @(posedge clk); #1;
    vec_we = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic run(input int g, input int cnt, input int p, input int f, input bit ap,
                     input int fidx, input logic [31:0] fdata, input logic [31:0] fpc);
    exp_t e;
    @(negedge clk);
    count = CW'(cnt); start_w[g] = 1'b1;
    @(posedge clk); #1;
    start_w[g] = 1'b0;
    e.lat = cnt * (2 + g * 3); e.pass = p; e.fail = f; e.allp = ap;
    e.fidx = fidx; e.fdata = fdata; e.fpc = fpc; e.scyc = cyc;
    if (g == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic wait_done(input int g, input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done_w[g] === 1'b1) break;
    end
    chk($sformatf("done_timeout%0d", g), (n < budget) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // Scoreboard monitor: compares on every rising done.
  initial begin
    bit   prev [2];
    exp_t e;
    prev[0] = 1'b0; prev[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (done_w[g] === 1'b1 && !prev[g]) begin
          if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
            chk($sformatf("unexpected_done%0d", g), 32'd1, 32'd0);
          end else begin
            e = (g == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("latency%0d", g), cyc - e.scyc, e.lat);
            chk($sformatf("pass_cnt%0d", g), 32'(pass_w[g]), e.pass);
            chk($sformatf("fail_cnt%0d", g), 32'(fail_w[g]), e.fail);
            chk($sformatf("all_pass%0d", g), 32'(all_pass_w[g]), 32'(e.allp));
            chk($sformatf("ff_idx%0d", g), 32'(ffidx_w[g]), e.fidx);
            chk($sformatf("ff_data%0d", g), ffdata_w[g], e.fdata);
            chk($sformatf("ff_pc%0d", g), ffpc_w[g], e.fpc);
            chk($sformatf("busy_in_done%0d", g), 32'(busy_w[g]), 32'd0);
          end
        end
        prev[g] = (done_w[g] === 1'b1);
      end
    end
  end

  initial begin
    start_w[0] = 1'b0; start_w[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst_w[0]), 32'd1);
    chk("rst_imem", imem_w[0], NOP);
    chk("rst_ra3", 32'(g_dut[0].bus.ra3), 32'd0);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_done", 32'(done_w[0]), 32'd0);
    chk("rst_all_pass", 32'(all_pass_w[0]), 32'd0);
    chk("rst_pass_cnt", 32'(pass_w[0]), 32'd0);
    chk("rst_fail_cnt", 32'(fail_w[0]), 32'd0);
    chk("rst_cpu_rst1", 32'(cpu_rst_w[1]), 32'd1);

    // Two passing LUIs.
    write_vec(0, 32'h186a_00b7, 5'd1, 32'h186a_0000);
    write_vec(1, 32'hffc1_8137, 5'd2, 32'hffc1_8000);
    run(0, 2, 2, 0, 1'b1, 0, 32'h0, 32'h0);
    wait_done(0, 20);
    chk("done_cpu_rst", 32'(cpu_rst_w[0]), 32'd0);
    chk("done_imem_nop", imem_w[0], NOP);

    // Wrong expectation on vector 1; PC of its issue cycle is 8.
    write_vec(1, 32'hffc1_8137, 5'd2, 32'hffc1_7000);
    pulse_rst();
    run(0, 2, 1, 1, 1'b0, 1, 32'hffc1_8000, 32'h8);
    wait_done(0, 20);

    // Illegal counts are ignored in IDLE.
    pulse_rst();
    @(negedge clk); count = CW'(0); start_w[0] = 1'b1;
    @(posedge clk); #1 start_w[0] = 1'b0;
    @(negedge clk);
    chk("cnt0_busy", 32'(busy_w[0]), 32'd0);
    chk("cnt0_cpu_rst", 32'(cpu_rst_w[0]), 32'd1);
    @(negedge clk); count = CW'(17); start_w[0] = 1'b1;
    @(posedge clk); #1 start_w[0] = 1'b0;
    @(negedge clk);
    chk("cnt17_busy", 32'(busy_w[0]), 32'd0);
    chk("cnt17_done", 32'(done_w[0]), 32'd0);

    // Start and table write mid-run are both ignored.
    write_vec(1, 32'hffc1_8137, 5'd2, 32'hffc1_8000);
    run(0, 2, 2, 0, 1'b1, 0, 32'h0, 32'h0);
    @(negedge clk);
    start_w[0] = 1'b1; count = CW'(1);
    vec_we = 1'b1; vec_idx = '0; vec_instr = NOP; vec_rd = 5'd3; vec_expect = 32'hdead_beef;
    @(posedge clk); #1;
    start_w[0] = 1'b0; vec_we = 1'b0;
    chk("midrun_busy", 32'(busy_w[0]), 32'd1);
    wait_done(0, 20);
    run(0, 1, 1, 0, 1'b1, 0, 32'h0, 32'h0);
    wait_done(0, 20);

    // Full table.
    for (int i = 0; i < 16; i++) begin
      logic [19:0] imm;
      imm = 20'h12300 + 20'(i);
      write_vec(i, {imm, 5'(i + 1), 7'b0110111}, 5'(i + 1), {imm, 12'h000});
    end
    run(0, 16, 16, 0, 1'b1, 0, 32'h0, 32'h0);
    wait_done(0, 60);

    // Settle instance: NOP spacing and done at cycle 10.
    write_vec(0, 32'h186a_00b7, 5'd1, 32'h186a_0000);
    write_vec(1, 32'hffc1_8137, 5'd2, 32'hffc1_8000);
    run(1, 2, 2, 0, 1'b1, 0, 32'h0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("settle_imem_c%0d", k + 1), imem_w[1],
          (k == 0) ? 32'h186a_00b7 : (k == 5) ? 32'hffc1_8137 : NOP);
    end
    wait_done(1, 20);

    // Reset during SETTLE of vector 1, then rerun.
    @(negedge clk); count = CW'(2); start_w[1] = 1'b1;
    @(posedge clk); #1 start_w[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_pass1", 32'(pass_w[1]), 32'd1);
    chk("pre_rst_busy1", 32'(busy_w[1]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_cpu_rst", 32'(cpu_rst_w[1]), 32'd1);
    chk("midrst_pass_cnt", 32'(pass_w[1]), 32'd0);
    chk("midrst_busy", 32'(busy_w[1]), 32'd0);
    run(1, 2, 2, 0, 1'b1, 0, 32'h0, 32'h0);
    wait_done(1, 30);

    chk("sb_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
